// File: rtl/mem_preloader_pkg.sv
// Shared constants for the memory preloader: operation modes, FSM state
// codes and the Galois LFSR step used for fill and verify data.
//   PL_MODE_*     2-bit operation selector latched at start
//   PL_ST_*       2-bit FSM state encoding
//   PL_LFSR_TAPS  feedback taps of the 16-bit right-shifting Galois LFSR
package mem_preloader_pkg;

  localparam logic [1:0] PL_MODE_ZERO        = 2'b00;
  localparam logic [1:0] PL_MODE_LFSR_FILL   = 2'b01;
  localparam logic [1:0] PL_MODE_STREAM_FILL = 2'b10;
  localparam logic [1:0] PL_MODE_LFSR_VERIFY = 2'b11;

  localparam logic [1:0] PL_ST_IDLE  = 2'b00;
  localparam logic [1:0] PL_ST_RUN   = 2'b01;
  localparam logic [1:0] PL_ST_DRAIN = 2'b10;
  localparam logic [1:0] PL_ST_DONE  = 2'b11;

  localparam logic [15:0] PL_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] pl_lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? PL_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mem_preloader_if.sv
// Bus bundle between the preloader and its neighbours: the stream-load
// handshake (s_valid/s_data/s_ready) and the single-port memory interface
// (mem_we/mem_addr/mem_din/mem_dout, read data one cycle after address).
//   master : preloader side (drives mem, accepts stream)
//   slave  : memory / stream source side
interface mem_preloader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    input  s_valid, s_data, mem_dout,
    output s_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    output s_valid, s_data, mem_dout,
    input  s_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_preloader_lfsr.sv
// pl_lfsr: 16-bit right-shifting Galois LFSR (taps 16'hB400).
//   clk, reset : clock, asynchronous active-high reset (state <= SEED)
//   load, seed : synchronous reload; load has priority over en
//   en         : advance one step
//   state      : current LFSR value (first word after load = seed)
module pl_lfsr
  import mem_preloader_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      state <= SEED;
    else if (load)  state <= seed;
    else if (en)    state <= pl_lfsr_step(state);
  end

endmodule

// File: rtl/mem_preloader.sv
// mem_preloader: memory initialisation engine. Zero-fills, LFSR-fills,
// stream-loads or LFSR-verifies length words starting at base_addr
// (addresses wrap). While busy it owns the memory port and holds the core.
//   clk, reset          : clock, asynchronous active-high reset
//   start, mode         : 1-cycle request (IDLE only) and operation select
//   base_addr, length   : region, latched at start
//   seed_in             : LFSR seed, 0 selects SEED
//   bus (master)        : stream handshake + memory port
//   busy, hold_core     : operation in progress
//   done                : 1-cycle pulse at end of operation
//   error, err_addr     : sticky verify mismatch and its first address
module mem_preloader
  import mem_preloader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [15:0]           seed_in,
  mem_preloader_if.master       bus,
  output logic                  busy,
  output logic                  hold_core,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  logic [1:0]            state;
  logic [1:0]            mode_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] len_r;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [15:0]           lfsr;
  logic [DATA_WIDTH-1:0] lfsr_word;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  is_stream;
  logic                  is_verify;
  logic                  all_issued;
  logic                  issue;
  logic                  mismatch;
  logic                  vld_p1;
  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] exp_p1;
  logic [DATA_WIDTH-1:0] exp_p2;
  logic [ADDR_WIDTH-1:0] addr_p2;

  assign is_stream  = (mode_r == PL_MODE_STREAM_FILL);
  assign is_verify  = (mode_r == PL_MODE_LFSR_VERIFY);
  assign all_issued = (cnt == len_r);
  assign lfsr_word  = DATA_WIDTH'(lfsr);

  // Only the first mismatch counts; once error is set the compare is muted.
  assign mismatch = vld_p2 && !error && (bus.mem_dout != exp_p2);

  // s_ready drops as soon as the last word has been accepted so the source
  // never sees a handshake that is not consumed.
  assign bus.s_ready = (state == PL_ST_RUN) && is_stream && !all_issued;

  assign issue = (state == PL_ST_RUN) && !all_issued && !mismatch &&
                 (!is_stream || bus.s_valid);

  always_comb begin
    wdata = '0;
    case (mode_r)
      PL_MODE_LFSR_FILL:   wdata = lfsr_word;
      PL_MODE_STREAM_FILL: wdata = bus.s_data;
      default:             wdata = '0;
    endcase
  end

  pl_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  ((state == PL_ST_IDLE) && start),
    .en    (issue),
    .seed  ((seed_in == 16'h0000) ? SEED : seed_in),
    .state (lfsr)
  );

  assign busy      = (state != PL_ST_IDLE);
  assign hold_core = busy;
  assign done      = (state == PL_ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PL_ST_IDLE;
      mode_r       <= PL_MODE_ZERO;
      base_r       <= '0;
      len_r        <= '0;
      cnt          <= '0;
      error        <= 1'b0;
      err_addr     <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
    end else begin
      // Issue stage: registered memory request, one word per issue.
      bus.mem_we <= issue && !is_verify;
      if (issue) begin
        bus.mem_addr <= base_r + cnt;
        cnt          <= cnt + 1'b1;
        if (!is_verify) bus.mem_din <= wdata;
      end
      // Verify pipeline: p1 = address on the bus, p2 = read data returning.
      vld_p1 <= issue && is_verify;
      vld_p2 <= vld_p1;

      case (state)
        PL_ST_IDLE: begin
          if (start) begin
            mode_r   <= mode;
            base_r   <= base_addr;
            len_r    <= length;
            cnt      <= '0;
            error    <= 1'b0;
            err_addr <= '0;
            state    <= PL_ST_RUN;
          end
        end
        PL_ST_RUN: begin
          if (mismatch) begin
            error    <= 1'b1;
            err_addr <= addr_p2;
            state    <= PL_ST_DRAIN;
          end else if (all_issued) begin
            state <= (is_verify && (len_r != '0)) ? PL_ST_DRAIN : PL_ST_DONE;
          end
        end
        PL_ST_DRAIN: begin
          if (mismatch) begin
            error    <= 1'b1;
            err_addr <= addr_p2;
          end
          // Nothing left behind the compare happening this cycle.
          if (!vld_p1) state <= PL_ST_DONE;
        end
        default: state <= PL_ST_IDLE;
      endcase
    end
  end

  // Expected-data pipeline, aligned with vld_p1/vld_p2.
  always_ff @(posedge clk) begin
    if (issue) exp_p1 <= lfsr_word;
    exp_p2  <= exp_p1;
    addr_p2 <= bus.mem_addr;
  end

endmodule

// File: tb/tb_mem_preloader.sv
module tb_mem_preloader;

  localparam logic [1:0] M_ZERO = 2'b00;
  localparam logic [1:0] M_LFSR = 2'b01;
  localparam logic [1:0] M_STRM = 2'b10;
  localparam logic [1:0] M_VRFY = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic [15:0] seed_in;
  logic        busy, hold_core, done, error;
  logic [15:0] err_addr;

  mem_preloader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  mem_preloader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .length    (length),
    .seed_in   (seed_in),
    .bus       (bus),
    .busy      (busy),
    .hold_core (hold_core),
    .done      (done),
    .error     (error),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wlog[$];
  logic [7:0]  mem [0:65535];
  logic        cor_en = 1'b0;
  logic [15:0] cor_a  = 16'h0000;

  // Synchronous memory model: read data one cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_din;
      wlog.push_back({bus.mem_addr, bus.mem_din});
    end else if (cor_en) begin
      mem[cor_a] <= mem[cor_a] ^ 8'hFF;
    end
    bus.mem_dout <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [15:0] b, input logic [15:0] l,
                        input logic [15:0] s, output int lat);
    wlog.delete();
    mode = m; base_addr = b; length = l; seed_in = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] seed;
    int          lat;
    int          n;
    logic [7:0]  d0;
    logic [15:0] a_last;
    logic [7:0]  d_last;
  } vec_t;

  vec_t vt[6];

  initial begin
    int          lat;
    int          bad;
    int          waited;
    logic [15:0] st;
    logic [15:0] addr_at_err;
    logic        saw;

    vt[0] = '{M_ZERO, 16'h0200, 16'd16, 16'h0000, 18, 16, 8'h00, 16'h020F, 8'h00};
    vt[1] = '{M_LFSR, 16'h1000, 16'd6,  16'hACE1, 8,  6,  8'hE1, 16'h1005, 8'h27};
    vt[2] = '{M_ZERO, 16'hFFFE, 16'd4,  16'h0000, 6,  4,  8'h00, 16'h0001, 8'h00};
    vt[3] = '{M_ZERO, 16'h0300, 16'd0,  16'h0000, 2,  0,  8'h00, 16'h0000, 8'h00};
    vt[4] = '{M_LFSR, 16'h2000, 16'd2,  16'h0000, 4,  2,  8'hE1, 16'h2001, 8'h70};
    vt[5] = '{M_LFSR, 16'h0010, 16'd2,  16'h0001, 4,  2,  8'h01, 16'h0011, 8'h00};

    reset = 1'b1; start = 1'b0; mode = M_ZERO; base_addr = 16'h0; length = 16'h0;
    seed_in = 16'h0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hold", hold_core, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;

    // Table-driven fill vectors
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].mode, vt[i].base, vt[i].len, vt[i].seed, lat);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_nwrites", i), wlog.size(), vt[i].n);
      chk($sformatf("v%0d_error", i), error, 0);
      if (wlog.size() == vt[i].n && vt[i].n > 0) begin
        chk($sformatf("v%0d_first_addr", i), wlog[0].a, vt[i].base);
        chk($sformatf("v%0d_first_data", i), wlog[0].d, vt[i].d0);
        chk($sformatf("v%0d_last_addr", i), wlog[vt[i].n-1].a, vt[i].a_last);
        chk($sformatf("v%0d_last_data", i), wlog[vt[i].n-1].d, vt[i].d_last);
        bad = 0;
        st = (vt[i].seed == 16'h0) ? 16'hACE1 : vt[i].seed;
        for (int j = 0; j < vt[i].n; j++) begin
          if (wlog[j].a != vt[i].base + 16'(j)) bad++;
          if (vt[i].mode == M_LFSR && wlog[j].d != st[7:0]) bad++;
          if (vt[i].mode == M_ZERO && wlog[j].d != 8'h00) bad++;
          st = m_step(st);
        end
        chk($sformatf("v%0d_sequence_bad", i), bad, 0);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Full 256-word LFSR fill, then clean verify
    run_op(M_LFSR, 16'h0000, 16'd256, 16'hACE1, lat);
    chk("fill256_latency", lat, 258);
    chk("fill256_mem0", mem[0], 8'hE1);
    chk("fill256_mem5", mem[5], 8'h27);
    bad = 0;
    st = 16'hACE1;
    for (int j = 0; j < 256; j++) begin
      if (mem[j] != st[7:0]) bad++;
      st = m_step(st);
    end
    chk("fill256_contents_bad", bad, 0);
    @(posedge clk); #1;
    run_op(M_VRFY, 16'h0000, 16'd256, 16'hACE1, lat);
    chk("verify_ok_error", error, 0);
    chk("verify_ok_nwrites", wlog.size(), 0);
    @(posedge clk); #1;

    // Corrupt mem[0005] and verify again
    cor_a = 16'h0005; cor_en = 1'b1;
    @(posedge clk); #1;
    cor_en = 1'b0;
    chk("corrupt_applied", mem[5], 8'hD8);
    mode = M_VRFY; base_addr = 16'h0000; length = 16'd256; seed_in = 16'hACE1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!error && !done && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("bad_error_set", error, 1);
    chk("bad_err_addr", err_addr, 16'h0005);
    addr_at_err = bus.mem_addr;
    waited = 0;
    while (!done && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("bad_done_seen", done, 1);
    chk("bad_no_more_issue", bus.mem_addr, addr_at_err);
    chk("bad_issue_bound", (bus.mem_addr <= 16'h0006) ? 1 : 0, 1);
    @(posedge clk); #1;
    chk("bad_error_sticky", error, 1);
    chk("bad_err_addr_sticky", err_addr, 16'h0005);
    run_op(M_ZERO, 16'h0050, 16'd1, 16'h0000, lat);
    chk("error_cleared_by_start", error, 0);
    @(posedge clk); #1;

    // STREAM_FILL with gapped s_valid 1,0,1,1,0,1
    wlog.delete();
    mode = M_STRM; base_addr = 16'h0700; length = 16'd4; seed_in = 16'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("strm_s_ready_run", bus.s_ready, 1);
    for (int k = 0; k < 6; k++) begin
      bus.s_valid = (k != 1 && k != 4);
      bus.s_data  = 8'hC0 | 8'(k);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    waited = 0;
    while (!done && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("strm_done_seen", done, 1);
    chk("strm_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("strm_w0", {wlog[0].a, wlog[0].d}, {16'h0700, 8'hC0});
      chk("strm_w1", {wlog[1].a, wlog[1].d}, {16'h0701, 8'hC2});
      chk("strm_w2", {wlog[2].a, wlog[2].d}, {16'h0702, 8'hC3});
      chk("strm_w3", {wlog[3].a, wlog[3].d}, {16'h0703, 8'hC5});
    end
    @(posedge clk); #1;
    chk("strm_s_ready_after", bus.s_ready, 0);

    // Reset in the middle of an LFSR fill
    wlog.delete();
    mode = M_LFSR; base_addr = 16'h3000; length = 16'd100; seed_in = 16'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("midrst_busy_before", busy, 1);
    chk("midrst_we_before", bus.mem_we, 1);
    reset = 1'b1;
    #1;
    chk("midrst_we", bus.mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hold", hold_core, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || bus.mem_we || busy) saw = 1'b1;
    end
    chk("midrst_quiet", saw, 0);
    run_op(M_ZERO, 16'h0040, 16'd3, 16'h0000, lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_nwrites", wlog.size(), 3);
    if (wlog.size() == 3)
      chk("post_rst_last_addr", wlog[2].a, 16'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
